// File: rtl/bpu_pkg.sv
// Shared types for the branch predict unit: funct3 codes, 2-bit counter states
// and the BTB entry layout. Entry fields are sized to BPU_MAX_XLEN; tags are zero-extended.
package bpu_pkg;

    localparam int BPU_MAX_XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic                    valid;
        logic [BPU_MAX_XLEN-1:0] tag;
        logic [BPU_MAX_XLEN-1:0] target;
        logic                    is_jump;
        ctr_e                    ctr;
    } btb_entry_t;

    function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
        ctr_e n;
        n = c;
        case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = WNT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped BTB storage: combinational IF read, synchronous write with a
// read-for-modify view of the entry being written, async clear to empty.
module bpu_btb
    import bpu_pkg::*;
#(
    parameter int BTB_ENTRIES = 64,
    localparam int IDX_W = $clog2(BTB_ENTRIES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    output btb_entry_t       o_rd_entry,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  btb_entry_t       i_wr_entry,
    output btb_entry_t       o_wr_old
);

    localparam btb_entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, is_jump: 1'b0, ctr: WNT};

    btb_entry_t r_tbl [BTB_ENTRIES];

    // Reads see the pre-edge contents; a same-cycle write is not bypassed.
    assign o_rd_entry = r_tbl[i_rd_idx];
    assign o_wr_old   = r_tbl[i_wr_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) r_tbl[i] <= RST_ENTRY;
        end else if (i_we) begin
            r_tbl[i_wr_idx] <= i_wr_entry;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict/resolve unit: BTB lookup at IF, resolve + mispredict at EX, table
// training on the following edge. Define BPU_STATS_EN to enable the perf counters.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_ex_valid,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_imm,
    input  logic [XLEN-1:0] i_ex_rs1_data,
    input  logic            i_ex_branch,
    input  logic            i_ex_jump,
    input  logic            i_ex_jalr,
    input  logic [2:0]      i_ex_funct3,
    input  logic            i_ex_zero,
    input  logic            i_ex_lt,
    input  logic            i_ex_ltu,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_stat_ctrl,
    output logic [31:0]     o_stat_mispred
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    btb_entry_t              w_rd, w_wr_old, w_wr_new;
    logic                    w_we, w_if_hit, w_ex_hit;
    logic [IDX_W-1:0]        w_if_idx, w_ex_idx;
    logic [BPU_MAX_XLEN-1:0] w_if_tag, w_ex_tag;
    logic                    w_ctrl, w_br_taken, w_taken;
    logic [XLEN-1:0]         w_act_target;
    logic                    w_unused;

    assign w_unused = ^{i_if_pc[1:0], i_ex_pc[1:0]};

    bpu_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_rd_idx   (w_if_idx),
        .o_rd_entry (w_rd),
        .i_we       (w_we),
        .i_wr_idx   (w_ex_idx),
        .i_wr_entry (w_wr_new),
        .o_wr_old   (w_wr_old)
    );

    assign w_if_idx      = i_if_pc[IDX_W+1:2];
    assign w_if_tag      = BPU_MAX_XLEN'(i_if_pc[XLEN-1:IDX_W+2]);
    assign w_if_hit      = w_rd.valid && (w_rd.tag == w_if_tag);
    assign o_pred_taken  = w_if_hit && (w_rd.is_jump || w_rd.ctr[1]);
    assign o_pred_target = o_pred_taken ? XLEN'(w_rd.target) : i_if_pc + XLEN'(4);

    always_comb begin
        w_br_taken = 1'b0;
        case (i_ex_funct3)
            F3_BEQ:  w_br_taken = i_ex_zero;
            F3_BNE:  w_br_taken = !i_ex_zero;
            F3_BLT:  w_br_taken = i_ex_lt;
            F3_BGE:  w_br_taken = !i_ex_lt;
            F3_BLTU: w_br_taken = i_ex_ltu;
            F3_BGEU: w_br_taken = !i_ex_ltu;
            default: w_br_taken = 1'b0;
        endcase
    end

    // A jump flag overrides a (illegal) simultaneous branch flag.
    assign w_ctrl       = i_ex_valid && (i_ex_branch || i_ex_jump);
    assign w_taken      = i_ex_jump || (i_ex_branch && w_br_taken);
    assign w_act_target = (i_ex_jump && i_ex_jalr) ? ((i_ex_rs1_data + i_ex_imm) & ~XLEN'(1))
                                                   : (i_ex_pc + i_ex_imm);

    assign o_redirect    = w_ctrl && ((w_taken != i_ex_pred_taken) ||
                                      (w_taken && (i_ex_pred_target != w_act_target)));
    assign o_redirect_pc = w_taken ? w_act_target : i_ex_pc + XLEN'(4);

    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag = BPU_MAX_XLEN'(i_ex_pc[XLEN-1:XLEN-TAG_W]);
    assign w_ex_hit = w_wr_old.valid && (w_wr_old.tag == w_ex_tag);

    always_comb begin
        w_we     = 1'b0;
        w_wr_new = w_wr_old;
        if (w_ctrl) begin
            if (w_ex_hit) begin
                w_we         = 1'b1;
                w_wr_new.ctr = ctr_next(w_wr_old.ctr, w_taken);
                if (w_taken) w_wr_new.target = BPU_MAX_XLEN'(w_act_target);
            end else if (w_taken) begin
                w_we     = 1'b1;
                w_wr_new = '{valid: 1'b1, tag: w_ex_tag, target: BPU_MAX_XLEN'(w_act_target),
                             is_jump: i_ex_jump, ctr: WT};
            end
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] r_stat_ctrl, r_stat_mispred;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_ctrl    <= '0;
            r_stat_mispred <= '0;
        end else begin
            r_stat_ctrl    <= r_stat_ctrl + 32'(w_ctrl);
            r_stat_mispred <= r_stat_mispred + 32'(o_redirect);
        end
    end

    assign o_stat_ctrl    = r_stat_ctrl;
    assign o_stat_mispred = r_stat_mispred;
`else
    assign o_stat_ctrl    = '0;
    assign o_stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (BTB_ENTRIES=4) against an array-based model.
module tb_branch_predict_unit;

`ifdef BPU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic [31:0] i_if_pc = '0, i_ex_pc = '0, i_ex_imm = '0, i_ex_rs1_data = '0, i_ex_pred_target = '0;
    logic        i_ex_valid = 1'b0, i_ex_branch = 1'b0, i_ex_jump = 1'b0, i_ex_jalr = 1'b0;
    logic [2:0]  i_ex_funct3 = '0;
    logic        i_ex_zero = 1'b0, i_ex_lt = 1'b0, i_ex_ltu = 1'b0, i_ex_pred_taken = 1'b0;
    logic        o_pred_taken, o_redirect;
    logic [31:0] o_pred_target, o_redirect_pc, o_stat_ctrl, o_stat_mispred;

    branch_predict_unit #(.XLEN(32), .BTB_ENTRIES(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_if_pc(i_if_pc),
        .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
        .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_imm(i_ex_imm), .i_ex_rs1_data(i_ex_rs1_data),
        .i_ex_branch(i_ex_branch), .i_ex_jump(i_ex_jump), .i_ex_jalr(i_ex_jalr), .i_ex_funct3(i_ex_funct3),
        .i_ex_zero(i_ex_zero), .i_ex_lt(i_ex_lt), .i_ex_ltu(i_ex_ltu),
        .i_ex_pred_taken(i_ex_pred_taken), .i_ex_pred_target(i_ex_pred_target),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
        .o_stat_ctrl(o_stat_ctrl), .o_stat_mispred(o_stat_mispred)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_pass = 0;

    // Reference model: 4-entry table indexed by pc[3:2], tag = pc >> 4.
    bit          m_v [4];
    logic [31:0] m_tag [4], m_tgt [4];
    bit          m_j [4];
    int          m_ctr [4];
    logic [31:0] m_ctrl, m_mis;
    bit          p_ctrl, p_taken, p_jmp, p_redir;
    logic [31:0] p_pc, p_tgt;
    bit          e_redir, e_ptk;
    logic [31:0] e_rpc, e_ptgt;

    function automatic bit cond_taken(input logic [2:0] f3, input bit z, input bit lt, input bit ltu);
        case (f3)
            3'b000: return z;
            3'b001: return !z;
            3'b100: return lt;
            3'b101: return !lt;
            3'b110: return ltu;
            3'b111: return !ltu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 4; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_j[i] = 0; m_ctr[i] = 1;
        end
        m_ctrl = '0; m_mis = '0; p_ctrl = 0; p_taken = 0; p_redir = 0;
    endtask

    task automatic drive(input bit v, input bit br, input bit jmp, input bit jalr, input logic [2:0] f3,
                         input bit z, input bit lt, input bit ltu, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input bit ptk,
                         input logic [31:0] ptgt, input logic [31:0] ifpc);
        int i;
        i_ex_valid = v; i_ex_branch = br; i_ex_jump = jmp; i_ex_jalr = jalr; i_ex_funct3 = f3;
        i_ex_zero = z; i_ex_lt = lt; i_ex_ltu = ltu; i_ex_pc = pc; i_ex_imm = imm;
        i_ex_rs1_data = rs1; i_ex_pred_taken = ptk; i_ex_pred_target = ptgt; i_if_pc = ifpc;
        p_ctrl  = v && (br || jmp);
        p_jmp   = jmp;
        p_taken = jmp || (br && cond_taken(f3, z, lt, ltu));
        p_tgt   = (jmp && jalr) ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
        p_pc    = pc;
        p_redir = p_ctrl && ((p_taken != ptk) || (p_taken && ptgt != p_tgt));
        e_redir = p_redir;
        e_rpc   = p_taken ? p_tgt : pc + 4;
        i       = int'((ifpc >> 2) % 4);
        e_ptk   = m_v[i] && (m_tag[i] == (ifpc >> 4)) && (m_j[i] || m_ctr[i] >= 2);
        e_ptgt  = e_ptk ? m_tgt[i] : ifpc + 4;
    endtask

    task automatic idle(input logic [31:0] ifpc);
        drive(0, 0, 0, 0, 3'b000, 0, 0, 0, '0, '0, '0, 0, '0, ifpc);
    endtask

    task automatic commit();
        int i;
        @(posedge i_clk);
        if (i_rst_n) begin
            if (p_ctrl) begin
                i = int'((p_pc >> 2) % 4);
                if (m_v[i] && m_tag[i] == (p_pc >> 4)) begin
                    m_ctr[i] = p_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                       : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                    if (p_taken) m_tgt[i] = p_tgt;
                end else if (p_taken) begin
                    m_v[i] = 1; m_tag[i] = p_pc >> 4; m_tgt[i] = p_tgt; m_j[i] = p_jmp; m_ctr[i] = 2;
                end
            end
            m_ctrl = m_ctrl + 32'(p_ctrl);
            m_mis  = m_mis + 32'(p_redir);
        end
        #1;
    endtask

    task automatic test_reset();
        mdl_clear();
        i_rst_n = 0;
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h100, 32'h40, '0, 0, '0, 32'h100);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_chk++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) $display("FAIL reset_lookup: got %b/%h want 0/00000104", o_pred_taken, o_pred_target);
        else n_pass++;
        n_chk++;
        if (o_stat_ctrl !== 32'h0 || o_stat_mispred !== 32'h0) $display("FAIL reset_stats: got %h/%h want 0/0", o_stat_ctrl, o_stat_mispred);
        else n_pass++;
        n_chk++;
        if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h140) $display("FAIL reset_redirect: got %b/%h want 1/00000140", o_redirect, o_redirect_pc);
        else n_pass++;
        idle(32'h100);
        @(negedge i_clk);
        i_rst_n = 1;
        #1;
        n_chk++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h104) $display("FAIL reset_no_write: got %b/%h want 0/00000104", o_pred_taken, o_pred_target);
        else n_pass++;
        commit();
    endtask

    task automatic test_cold_beq();
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h200, 32'h40, '0, 0, '0, 32'h300);
        @(negedge i_clk);
        n_chk++;
        if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h240) $display("FAIL cold_beq_redirect: got %b/%h want 1/00000240", o_redirect, o_redirect_pc);
        else n_pass++;
        commit();
        idle(32'h200);
        @(negedge i_clk);
        n_chk++;
        if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h240) $display("FAIL cold_beq_predict: got %b/%h want 1/00000240", o_pred_taken, o_pred_target);
        else n_pass++;
        commit();
    endtask

    task automatic test_saturation();
        drive(1, 1, 0, 0, 3'b001, 0, 0, 0, 32'h404, 32'h20, '0, 0, '0, 32'h0);
        commit();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 3'b001, 1, 0, 0, 32'h404, 32'h20, '0, 0, '0, 32'h0);
            commit();
        end
        idle(32'h404);
        @(negedge i_clk);
        n_chk++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h408) $display("FAIL sat_low: got %b/%h want 0/00000408", o_pred_taken, o_pred_target);
        else n_pass++;
        drive(1, 1, 0, 0, 3'b001, 0, 0, 0, 32'h404, 32'h20, '0, 0, '0, 32'h0);
        commit();
        idle(32'h404);
        @(negedge i_clk);
        n_chk++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== e_ptgt) $display("FAIL sat_one_taken: got %b/%h want 0/%h", o_pred_taken, o_pred_target, e_ptgt);
        else n_pass++;
        commit();
    endtask

    task automatic test_jalr();
        drive(1, 0, 1, 1, 3'b000, 0, 0, 0, 32'h508, 32'h4, 32'h1003, 1, 32'h1008, 32'h0);
        @(negedge i_clk);
        n_chk++;
        if (o_redirect !== 1'b1 || o_redirect_pc !== 32'h1006) $display("FAIL jalr_redirect: got %b/%h want 1/00001006", o_redirect, o_redirect_pc);
        else n_pass++;
        commit();
        idle(32'h508);
        @(negedge i_clk);
        n_chk++;
        if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h1006) $display("FAIL jalr_predict: got %b/%h want 1/00001006", o_pred_taken, o_pred_target);
        else n_pass++;
        commit();
    endtask

    task automatic test_collision();
        drive(1, 0, 1, 0, 3'b000, 0, 0, 0, 32'h10, 32'h70, '0, 0, '0, 32'h0);
        commit();
        drive(1, 1, 0, 0, 3'b000, 1, 0, 0, 32'h20, 32'h100, '0, 0, '0, 32'h10);
        @(negedge i_clk);
        n_chk++;
        if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) $display("FAIL collision_old_entry: got %b/%h want 1/00000080", o_pred_taken, o_pred_target);
        else n_pass++;
        commit();
        idle(32'h10);
        @(negedge i_clk);
        n_chk++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'h14) $display("FAIL alias_evicted: got %b/%h want 0/00000014", o_pred_taken, o_pred_target);
        else n_pass++;
        idle(32'h20);
        #1;
        n_chk++;
        if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h120) $display("FAIL alias_new: got %b/%h want 1/00000120", o_pred_taken, o_pred_target);
        else n_pass++;
        commit();
    endtask

    task automatic test_bgeu_stats();
        logic [31:0] c0, m0;
        drive(1, 1, 0, 0, 3'b111, 0, 0, 0, 32'h608, 32'h30, '0, 0, '0, 32'h0);
        commit();
        c0 = o_stat_ctrl; m0 = o_stat_mispred;
        drive(1, 1, 0, 0, 3'b111, 0, 1, 0, 32'h608, 32'h30, '0, 1, 32'h638, 32'h608);
        @(negedge i_clk);
        n_chk++;
        if (o_redirect !== 1'b0 || o_pred_taken !== 1'b1) $display("FAIL bgeu_no_redirect: got %b/%b want 0/1", o_redirect, o_pred_taken);
        else n_pass++;
        commit();
        @(negedge i_clk);
        n_chk++;
        if (o_stat_ctrl !== (STATS ? c0 + 1 : 32'h0) || o_stat_mispred !== (STATS ? m0 : 32'h0))
            $display("FAIL bgeu_stats: got %h/%h want %h/%h", o_stat_ctrl, o_stat_mispred,
                     STATS ? c0 + 1 : 32'h0, STATS ? m0 : 32'h0);
        else n_pass++;
        n_chk++;
        if (o_stat_ctrl !== (STATS ? m_ctrl : 32'h0) || o_stat_mispred !== (STATS ? m_mis : 32'h0))
            $display("FAIL stats_total: got %h/%h want %h/%h", o_stat_ctrl, o_stat_mispred,
                     STATS ? m_ctrl : 32'h0, STATS ? m_mis : 32'h0);
        else n_pass++;
    endtask

    task automatic test_random();
        bit v, br, jmp, jalr, ptk;
        int cls;
        logic [31:0] pc, imm, rs1, ifpc, tgt, ptgt;
        for (int n = 0; n < 300; n++) begin
            v    = ($urandom_range(0, 9) != 0);
            cls  = $urandom_range(0, 4);
            br   = (cls == 1) || (cls == 4);
            jmp  = (cls >= 2);
            jalr = (cls == 3) ? 1'b1 : 1'($urandom_range(0, 1) & (cls == 0 ? 1 : 0));
            pc   = 32'($urandom_range(0, 15)) << 2;
            ifpc = 32'($urandom_range(0, 15)) << 2;
            imm  = 32'($urandom_range(0, 63)) << 2;
            rs1  = $urandom;
            tgt  = (jmp && jalr) ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
            ptk  = 1'($urandom_range(0, 1));
            ptgt = ($urandom_range(0, 3) != 0) ? tgt : pc + 8;
            drive(v, br, jmp, jalr, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pc, imm, rs1, ptk, ptgt, ifpc);
            @(negedge i_clk);
            n_chk++;
            if (o_redirect !== e_redir || o_redirect_pc !== e_rpc || o_pred_taken !== e_ptk ||
                o_pred_target !== e_ptgt || o_stat_ctrl !== (STATS ? m_ctrl : 32'h0) ||
                o_stat_mispred !== (STATS ? m_mis : 32'h0))
                $display("FAIL random[%0d]: got rd=%b rpc=%h pt=%b ptg=%h sc=%h sm=%h want rd=%b rpc=%h pt=%b ptg=%h sc=%h sm=%h",
                         n, o_redirect, o_redirect_pc, o_pred_taken, o_pred_target, o_stat_ctrl, o_stat_mispred,
                         e_redir, e_rpc, e_ptk, e_ptgt, STATS ? m_ctrl : 32'h0, STATS ? m_mis : 32'h0);
            else n_pass++;
            commit();
        end
    endtask

    initial begin
        test_reset();
        test_cold_beq();
        test_saturation();
        test_jalr();
        test_collision();
        test_bgeu_stats();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolution and prediction unit for the 5-stage RV32 pipeline.
- **IF side:** a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters supplies a predicted next PC.
- **EX side:** branches and jumps are resolved, the prediction is checked, and a redirect/flush is raised only on mispredict.
- **Table update:** trained at the clock edge following each resolved control-flow instruction.

## Interface
Parameters:
- XLEN, 32, data/address width.
- BTB_ENTRIES, 64, table depth; power of two, ≥2. IDX_W = log2(BTB_ENTRIES), TAG_W = XLEN-IDX_W-2.

Ports:
- clk  in  1  clock. Everything is sampled on the rising edge.
- rst_n  in  1  reset. Asynchronous assertion, active-low.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  IF prediction: redirect fetch to pred_target.
- pred_target  out  XLEN  predicted next PC; equals if_pc+4 when pred_taken=0.
- ex_valid  in  1  EX holds a real instruction (0 on bubble/stall).
- ex_pc, ex_imm, ex_rs1_data  in  XLEN  each; EX PC, immediate, and rs1 operand.
- ex_branch, ex_jump, ex_jalr  in  1  each; instruction class. ex_jalr is meaningful only with ex_jump.
- ex_funct3  in  3  branch condition.
- ex_zero, ex_lt, ex_ltu  in  1  each; ALU compare flags for rs1 vs rs2.
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- ex_pred_target  in  XLEN  predicted target carried down the pipe with the instruction.
- redirect  out  1  mispredict: flush IF/ID and load redirect_pc.
- redirect_pc  out  XLEN  corrected PC.
- stat_ctrl, stat_mispred  out  32  each; performance counters (see Configuration).

## Operation
- **Lookup:** index = if_pc[IDX_W+1:2], tag = if_pc[XLEN-1:IDX_W+2]. It is a hit when entry valid and tag matches. pred_taken = hit & (entry.is_jump | entry.ctr[1]).
- **Branch resolve:** taken per funct3 as follows. Other funct3 values are not taken.
  - BEQ 000: zero.
  - BNE 001: !zero.
  - BLT 100: lt.
  - BGE 101: !lt.
  - BLTU 110: ltu.
  - BGEU 111: !ltu.
- **Jump resolve:** jumps are always taken.
- **Actual target:**
  - JAL and branch: ex_pc+ex_imm.
  - JALR: (ex_rs1_data+ex_imm) & ~1.
  - All adds are modulo 2^XLEN.
- **Mispredict:** redirect = ex_valid & (ex_branch|ex_jump) & ((taken != ex_pred_taken) | (taken & ex_pred_target != actual_target)). redirect_pc = taken ? actual_target : ex_pc+4.
- **Update:** happens on the next edge when ex_valid & (ex_branch|ex_jump).
  - Tag hit: counter increments on taken and decrements on not-taken, saturating at 00/11. If taken, target is rewritten.
  - Tag miss & taken: allocate the entry (valid=1, new tag, target, is_jump=ex_jump, ctr=10), replacing any occupant.
  - Tag miss & not-taken: no write.
- **Read/write collision:** an IF lookup and an EX write to the same index in the same cycle returns the pre-write contents. There is no bypass.
- **Non-control or invalid EX:** no table change and redirect=0.
- **Simultaneous ex_branch & ex_jump:** illegal. ex_jump wins.

## Timing
- Lookup and resolve are both combinational (0 cycles). The table write takes effect 1 cycle after resolve.
- Reset (async, rst_n=0):
  - all valid bits 0, all counters 01;
  - pred_taken=0, pred_target=if_pc+4;
  - stats 0.
  - redirect follows the EX inputs but no write occurs while rst_n=0.
- Reset mid-update: a pending write is discarded, and the table is empty after release.
- Release is synchronous to the first clk edge with rst_n=1.

## Configuration
- BPU_STATS_EN defined:
  - stat_ctrl counts every resolved control instruction;
  - stat_mispred counts every cycle with redirect=1;
  - both are 32-bit and wrap at 2^32.
- Undefined: stat_ctrl and stat_mispred are tied to 0 and no counter flops are inferred. The port list is unchanged.

## Structure
- **bpu_pkg:**
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU;
  - counter encodings: SNT=00, WNT=01, WT=10, ST=11;
  - btb_entry_t struct {valid, tag, target, is_jump, ctr}.
- **Sub-module bpu_btb:** the entry array, with one combinational read port, one synchronous write port, and async clear. The top level holds the resolve, compare, update and stats logic.

## Test plan
- **Reset:** rst_n=0, then release; if_pc=0x100 → pred_taken=0, pred_target=0x104, stats=0.
- **Cold BEQ:** ex_pc=0x200, imm=0x40, zero=1, ex_pred_taken=0.
  - Same cycle → redirect=1, redirect_pc=0x240.
  - Next cycle, if_pc=0x200 → pred_taken=1, pred_target=0x240.
- **Counter saturation:** the same BNE is resolved not-taken 3× after allocation (ctr 10→01→00→00).
  - Lookup → pred_taken=0.
  - One further taken → ctr=01, still pred_taken=0.
- **JALR target and alignment:** rs1=0x1003, imm=4 → actual_target=0x1006. With ex_pred_target=0x1008 and ex_pred_taken=1 → redirect=1, redirect_pc=0x1006.
- **Collision and aliasing:** BTB_ENTRIES=4.
  - 0x10 and 0x20 alias to index 0, with different tags.
  - Taken at 0x20 evicts 0x10, so lookup of 0x10 misses.
  - A same-cycle IF read of index 0 during the write returns the old entry.
- **Stats and BGEU:** BGEU with ltu=0 predicted taken to the correct target → redirect=0. With BPU_STATS_EN, stat_ctrl increments and stat_mispred holds.
